// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage:
// bus FSM encoding, lane-select codes, timeout limit, store lane helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } bus_state_e;

    localparam logic [3:0] BSEL_B0 = 4'b0001;
    localparam logic [3:0] BSEL_B1 = 4'b0010;
    localparam logic [3:0] BSEL_B2 = 4'b0100;
    localparam logic [3:0] BSEL_B3 = 4'b1000;
    localparam logic [3:0] BSEL_H0 = 4'b0011;
    localparam logic [3:0] BSEL_H1 = 4'b1100;
    localparam logic [3:0] BSEL_W  = 4'b1111;

    localparam int unsigned TIMEOUT = 255;
    // Last BUSY count value before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Replicate store data so every enabled lane sees the right bytes.
    function automatic logic [31:0] store_lanes(
        input logic [3:0]  be,
        input logic [31:0] rt
    );
        logic [31:0] w;
        w = rt;
        case (be)
            BSEL_B0, BSEL_B1,
            BSEL_B2, BSEL_B3: w = {4{rt[7:0]}};
            BSEL_H0, BSEL_H1: w = {2{rt[15:0]}};
            default:          w = rt;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: right-justifies the selected lanes of a read word and
// zero/sign extends. Ports: rdata_i, bytesel_i, extsigned_i -> data_o.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [3:0]  bytesel_i,
    input  logic        extsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = rdata_i[7:0];
        h      = rdata_i[15:0];
        data_o = rdata_i;
        case (bytesel_i)
            BSEL_B1: b = rdata_i[15:8];
            BSEL_B2: b = rdata_i[23:16];
            BSEL_B3: b = rdata_i[31:24];
            BSEL_H1: h = rdata_i[31:16];
            default: ;
        endcase
        case (bytesel_i)
            BSEL_B0, BSEL_B1,
            BSEL_B2, BSEL_B3: data_o = {{24{extsigned_i & b[7]}}, b};
            BSEL_H0, BSEL_H1: data_o = {{16{extsigned_i & h[15]}}, h};
            default:          data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data bus (IDLE/BUSY/DONE), stalls the
// front of the pipe during accesses, and registers the MEM/WB outputs.
// Ports: EX/MEM controls+data in, dbus_* bus, mem_stall_o, wb_*, bus_err_o.
module mem_access_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_regwr_i,
    input  logic        mem_memtoreg_i,
    input  logic        mem_memwr_i,
    input  logic        mem_dmen_i,
    input  logic [3:0]  mem_bytesel_i,
    input  logic        mem_extsigned_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] mem_rt_i,
    input  logic [4:0]  mem_regdst_addr_i,
    input  logic [31:0] mem_pc_i,
    input  logic        wash_memwb_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_be_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        mem_stall_o,
    output logic        wb_regwr_o,
    output logic [4:0]  wb_regdst_addr_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] wb_pc_o,
    output logic        bus_err_o
);

    bus_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        busy;
    logic        bubble;
    logic [31:0] load_data;

    logic        wb_regwr_q, wb_regwr_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] wb_pc_q, wb_pc_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_dmen_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (dbus_ack_i) begin
                    rdata_d = dbus_rdata_i;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Abandon the access: retire zero, flag sticky error.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy         = (state_q == ST_BUSY);
    assign dbus_req_o   = busy;
    assign dbus_we_o    = busy & mem_memwr_i;
    assign dbus_be_o    = busy ? mem_bytesel_i : 4'b0000;
    assign dbus_addr_o  = busy ? {mem_result_i[31:2], 2'b00} : 32'd0;
    assign dbus_wdata_o = busy ? store_lanes(mem_bytesel_i, mem_rt_i)
                               : 32'd0;

    assign mem_stall_o = mem_dmen_i & (state_q != ST_DONE);

    load_align u_load_align (
        .rdata_i     (rdata_q),
        .bytesel_i   (mem_bytesel_i),
        .extsigned_i (mem_extsigned_i),
        .data_o      (load_data)
    );

    assign bubble = wash_memwb_i | mem_stall_o;

    always_comb begin
        wb_regwr_d = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        wb_pc_d    = '0;
        if (!bubble) begin
            wb_regwr_d = mem_regwr_i;
            wb_rd_d    = mem_regdst_addr_i;
            wb_pc_d    = mem_pc_i;
            wb_data_d  = mem_memtoreg_i ? load_data : mem_result_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wb_regwr_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wb_regwr_q <= wb_regwr_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
        end
    end

    assign wb_regwr_o       = wb_regwr_q;
    assign wb_regdst_addr_o = wb_rd_q;
    assign wb_data_o        = wb_data_q;
    assign wb_pc_o          = wb_pc_q;
    assign bus_err_o        = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: randomized accesses checked
// against a lane/extension reference model and cycle-count expectations.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_regwr_i, mem_memtoreg_i, mem_memwr_i, mem_dmen_i;
    logic [3:0]  mem_bytesel_i;
    logic        mem_extsigned_i;
    logic [31:0] mem_result_i, mem_rt_i, mem_pc_i;
    logic [4:0]  mem_regdst_addr_i;
    logic        wash_memwb_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        mem_stall_o;
    logic        wb_regwr_o;
    logic [4:0]  wb_regdst_addr_o;
    logic [31:0] wb_data_o, wb_pc_o;
    logic        bus_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage dut (
        .clk               (clk),
        .reset             (reset),
        .mem_regwr_i       (mem_regwr_i),
        .mem_memtoreg_i    (mem_memtoreg_i),
        .mem_memwr_i       (mem_memwr_i),
        .mem_dmen_i        (mem_dmen_i),
        .mem_bytesel_i     (mem_bytesel_i),
        .mem_extsigned_i   (mem_extsigned_i),
        .mem_result_i      (mem_result_i),
        .mem_rt_i          (mem_rt_i),
        .mem_regdst_addr_i (mem_regdst_addr_i),
        .mem_pc_i          (mem_pc_i),
        .wash_memwb_i      (wash_memwb_i),
        .dbus_req_o        (dbus_req_o),
        .dbus_we_o         (dbus_we_o),
        .dbus_addr_o       (dbus_addr_o),
        .dbus_wdata_o      (dbus_wdata_o),
        .dbus_be_o         (dbus_be_o),
        .dbus_ack_i        (dbus_ack_i),
        .dbus_rdata_i      (dbus_rdata_i),
        .mem_stall_o       (mem_stall_o),
        .wb_regwr_o        (wb_regwr_o),
        .wb_regdst_addr_o  (wb_regdst_addr_o),
        .wb_data_o         (wb_data_o),
        .wb_pc_o           (wb_pc_o),
        .bus_err_o         (bus_err_o)
    );

    always #5 clk = ~clk;

    // Reference: pick the lanes by position, shift down, mask, extend.
    function automatic logic [31:0] exp_load(input logic [31:0] rd,
                                             input logic [3:0] be,
                                             input bit sgn);
        int lo, n;
        logic [63:0] v, mask;
        lo = 0;
        n  = 0;
        for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
        for (int i = 0; i < 4; i++) if (be[i]) n++;
        if (n == 4) return rd;
        v    = 64'(rd) >> (8 * lo);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (sgn && v >= ((mask + 64'd1) >> 1))
            v = v | (64'hFFFF_FFFF & ~mask);
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] rt,
                                              input logic [3:0] be);
        int n;
        logic [31:0] b, h;
        n = 0;
        for (int i = 0; i < 4; i++) if (be[i]) n++;
        b = rt & 32'hFF;
        h = rt & 32'hFFFF;
        if (n == 1) return b * 32'h0101_0101;
        if (n == 2) return h * 32'h0001_0001;
        return rt;
    endfunction

    task automatic drive_nop();
        mem_regwr_i       = 1'b0;
        mem_memtoreg_i    = 1'b0;
        mem_memwr_i       = 1'b0;
        mem_dmen_i        = 1'b0;
        mem_bytesel_i     = 4'b0000;
        mem_extsigned_i   = 1'b0;
        mem_result_i      = 32'd0;
        mem_rt_i          = 32'd0;
        mem_regdst_addr_i = 5'd0;
        mem_pc_i          = 32'd0;
        wash_memwb_i      = 1'b0;
        dbus_ack_i        = 1'b0;
        dbus_rdata_i      = 32'd0;
    endtask

    // Runs one memory instruction; starts and ends at posedge+1(+1).
    // lat = number of request cycles before ack (0 = never ack).
    task automatic run_access(
        input  logic        we,
        input  logic [3:0]  be,
        input  logic [31:0] addr,
        input  logic [31:0] rt,
        input  logic [31:0] rdata,
        input  logic        sgn,
        input  logic        m2r,
        input  logic        rw,
        input  logic [4:0]  rd,
        input  logic [31:0] pc,
        input  logic        wash,
        input  int          lat,
        output int          stall_n,
        output int          req_n,
        output bit          bubble_ok,
        output bit          hung,
        output logic [31:0] o_addr,
        output logic        o_we,
        output logic [3:0]  o_be,
        output logic [31:0] o_wdata
    );
        mem_dmen_i        = 1'b1;
        mem_memwr_i       = we;
        mem_memtoreg_i    = m2r;
        mem_regwr_i       = rw;
        mem_bytesel_i     = be;
        mem_extsigned_i   = sgn;
        mem_result_i      = addr;
        mem_rt_i          = rt;
        mem_regdst_addr_i = rd;
        mem_pc_i          = pc;
        wash_memwb_i      = wash;
        dbus_ack_i        = 1'b0;
        dbus_rdata_i      = $urandom;
        stall_n   = 0;
        req_n     = 0;
        bubble_ok = 1'b1;
        hung      = 1'b1;
        o_addr    = '0;
        o_we      = 1'b0;
        o_be      = '0;
        o_wdata   = '0;
        #1;
        for (int c = 0; c < 400; c++) begin
            if (mem_stall_o) stall_n++;
            if (c > 0 && (wb_regwr_o || wb_data_o != 0 ||
                wb_regdst_addr_o != 0 || wb_pc_o != 0))
                bubble_ok = 1'b0;
            if (dbus_req_o) begin
                req_n++;
                if (req_n == 1) begin
                    o_addr  = dbus_addr_o;
                    o_we    = dbus_we_o;
                    o_be    = dbus_be_o;
                    o_wdata = dbus_wdata_o;
                end
                if (req_n == lat) begin
                    dbus_ack_i   = 1'b1;
                    dbus_rdata_i = rdata;
                end
            end
            if (!mem_stall_o) begin
                hung = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            dbus_ack_i   = 1'b0;
            dbus_rdata_i = $urandom;
            #1;
        end
        @(posedge clk);
        #2;
        drive_nop();
    endtask

    task automatic test_reset();
        drive_nop();
        reset = 1'b0;
        #12;
        n_cmp++; if (dbus_req_o !== 1'b0) begin n_bad++;
            $display("FAIL reset_req: got %b want 0", dbus_req_o); end
        n_cmp++; if (mem_stall_o !== 1'b0) begin n_bad++;
            $display("FAIL reset_stall: got %b want 0", mem_stall_o); end
        n_cmp++; if (bus_err_o !== 1'b0) begin n_bad++;
            $display("FAIL reset_err: got %b want 0", bus_err_o); end
        n_cmp++; if ({wb_regwr_o, wb_regdst_addr_o, wb_data_o, wb_pc_o} !== '0) begin
            n_bad++; $display("FAIL reset_wb: got %h/%h/%h/%h want 0",
                wb_regwr_o, wb_regdst_addr_o, wb_data_o, wb_pc_o); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_alu();
        logic [31:0] r, p;
        logic [4:0]  d;
        logic        w;
        for (int i = 0; i < 8; i++) begin
            r = (i == 0) ? 32'h1234_5678 : $urandom;
            d = (i == 0) ? 5'd5 : 5'($urandom);
            p = $urandom;
            w = (i == 0) ? 1'b1 : 1'($urandom);
            drive_nop();
            mem_result_i      = r;
            mem_regdst_addr_i = d;
            mem_pc_i          = p;
            mem_regwr_i       = w;
            mem_rt_i          = $urandom;
            #1;
            n_cmp++; if (mem_stall_o !== 1'b0 || dbus_req_o !== 1'b0) begin
                n_bad++; $display("FAIL alu_stall[%0d]: got %b/%b want 0/0",
                    i, mem_stall_o, dbus_req_o); end
            @(posedge clk);
            #2;
            n_cmp++; if (wb_data_o !== r || wb_regdst_addr_o !== d ||
                         wb_pc_o !== p || wb_regwr_o !== w) begin
                n_bad++; $display("FAIL alu_wb[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b",
                    i, wb_data_o, wb_regdst_addr_o, wb_pc_o, wb_regwr_o, r, d, p, w); end
        end
    endtask

    task automatic test_word_load();
        int sn, rn; bit bok, hg;
        logic [31:0] oa, ow; logic owe; logic [3:0] ob;
        run_access(1'b0, 4'b1111, 32'h100, 32'd0, 32'hDEAD_BEEF, 1'b0,
                   1'b1, 1'b1, 5'd7, 32'h40, 1'b0, 3,
                   sn, rn, bok, hg, oa, owe, ob, ow);
        n_cmp++; if (hg || sn != 4 || rn != 3) begin n_bad++;
            $display("FAIL word_cycles: got stall=%0d req=%0d hung=%0b want 4/3/0",
                sn, rn, hg); end
        n_cmp++; if (!bok) begin n_bad++;
            $display("FAIL word_bubble: got nonzero wb want bubble"); end
        n_cmp++; if (oa !== 32'h100 || owe !== 1'b0 || ob !== 4'b1111) begin
            n_bad++; $display("FAIL word_bus: got %h/%b/%b want 100/0/1111",
                oa, owe, ob); end
        n_cmp++; if (wb_data_o !== 32'hDEAD_BEEF || wb_regdst_addr_o !== 5'd7 ||
                     wb_regwr_o !== 1'b1 || wb_pc_o !== 32'h40) begin
            n_bad++; $display("FAIL word_wb: got %h/%h/%b/%h want deadbeef/07/1/40",
                wb_data_o, wb_regdst_addr_o, wb_regwr_o, wb_pc_o); end
        @(posedge clk);
        #2;
        n_cmp++; if (wb_data_o !== 32'd0 || wb_regwr_o !== 1'b0) begin n_bad++;
            $display("FAIL word_once: got %h/%b want 0/0", wb_data_o, wb_regwr_o); end
    endtask

    task automatic test_signed_byte();
        int sn, rn; bit bok, hg;
        logic [31:0] oa, ow; logic owe; logic [3:0] ob;
        logic [31:0] want;
        for (int s = 1; s >= 0; s--) begin
            want = s ? 32'hFFFF_FF80 : 32'h0000_0080;
            run_access(1'b0, 4'b0100, 32'h202, 32'd0, 32'h0080_0000, 1'(s),
                       1'b1, 1'b1, 5'd3, 32'h80, 1'b0, 1,
                       sn, rn, bok, hg, oa, owe, ob, ow);
            n_cmp++; if (hg || wb_data_o !== want || oa !== 32'h200) begin
                n_bad++; $display("FAIL byte_load[s=%0d]: got %h addr %h want %h addr 200",
                    s, wb_data_o, oa, want); end
        end
    endtask

    task automatic test_half_store();
        int sn, rn; bit bok, hg;
        logic [31:0] oa, ow; logic owe; logic [3:0] ob;
        run_access(1'b1, 4'b1100, 32'h300, 32'h0000_ABCD, 32'h0, 1'b0,
                   1'b0, 1'b0, 5'd9, 32'hC0, 1'b0, 2,
                   sn, rn, bok, hg, oa, owe, ob, ow);
        n_cmp++; if (ow !== 32'hABCD_ABCD || ob !== 4'b1100 || owe !== 1'b1) begin
            n_bad++; $display("FAIL half_store_bus: got %h/%b/%b want abcdabcd/1100/1",
                ow, ob, owe); end
        n_cmp++; if (hg || wb_regwr_o !== 1'b0 || sn != 3 || rn != 2) begin
            n_bad++; $display("FAIL half_store_wb: got regwr=%b stall=%0d req=%0d want 0/3/2",
                wb_regwr_o, sn, rn); end
    endtask

    task automatic test_random();
        logic [3:0]  be_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111};
        int sn, rn, lat; bit bok, hg;
        logic [31:0] oa, ow; logic owe; logic [3:0] ob;
        logic [31:0] a, rt, rdv, p, want;
        logic [3:0] be; logic we, sg, m2r; logic [4:0] d;
        for (int i = 0; i < 24; i++) begin
            be  = be_tab[$urandom_range(0, 6)];
            a   = $urandom;
            rt  = $urandom;
            rdv = $urandom;
            p   = $urandom;
            d   = 5'($urandom);
            we  = 1'($urandom);
            sg  = 1'($urandom);
            m2r = ~we;
            lat = $urandom_range(1, 6);
            run_access(we, be, a, rt, rdv, sg, m2r, m2r, d, p, 1'b0, lat,
                       sn, rn, bok, hg, oa, owe, ob, ow);
            want = m2r ? exp_load(rdv, be, sg) : a;
            n_cmp++; if (hg || sn != lat + 1 || rn != lat || !bok) begin
                n_bad++; $display("FAIL rnd_timing[%0d]: got stall=%0d req=%0d bub=%0b want %0d/%0d/1",
                    i, sn, rn, bok, lat + 1, lat); end
            n_cmp++; if (oa !== (a & 32'hFFFF_FFFC) || ob !== be || owe !== we ||
                         (we && ow !== exp_wdata(rt, be))) begin
                n_bad++; $display("FAIL rnd_bus[%0d]: got %h/%b/%b/%h want %h/%b/%b/%h",
                    i, oa, ob, owe, ow, a & 32'hFFFF_FFFC, be, we, exp_wdata(rt, be)); end
            n_cmp++; if (wb_data_o !== want || wb_regdst_addr_o !== d ||
                         wb_pc_o !== p || wb_regwr_o !== m2r) begin
                n_bad++; $display("FAIL rnd_wb[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b",
                    i, wb_data_o, wb_regdst_addr_o, wb_pc_o, wb_regwr_o, want, d, p, m2r); end
        end
    endtask

    task automatic test_wash();
        int sn, rn; bit bok, hg;
        logic [31:0] oa, ow; logic owe; logic [3:0] ob;
        run_access(1'b0, 4'b1111, 32'h500, 32'd0, 32'h1357_9BDF, 1'b0,
                   1'b1, 1'b1, 5'd11, 32'h88, 1'b1, 4,
                   sn, rn, bok, hg, oa, owe, ob, ow);
        n_cmp++; if (hg || rn != 4 || sn != 5) begin n_bad++;
            $display("FAIL wash_access: got req=%0d stall=%0d want 4/5", rn, sn); end
        n_cmp++; if ({wb_regwr_o, wb_regdst_addr_o, wb_data_o, wb_pc_o} !== '0) begin
            n_bad++; $display("FAIL wash_wb: got %b/%h/%h/%h want 0",
                wb_regwr_o, wb_regdst_addr_o, wb_data_o, wb_pc_o); end
    endtask

    task automatic test_timeout();
        int sn, rn; bit bok, hg;
        logic [31:0] oa, ow; logic owe; logic [3:0] ob;
        n_cmp++; if (bus_err_o !== 1'b0) begin n_bad++;
            $display("FAIL pre_timeout_err: got %b want 0", bus_err_o); end
        run_access(1'b0, 4'b1111, 32'h600, 32'd0, 32'hFFFF_FFFF, 1'b1,
                   1'b1, 1'b1, 5'd12, 32'h90, 1'b0, 0,
                   sn, rn, bok, hg, oa, owe, ob, ow);
        n_cmp++; if (hg || rn != 255 || sn != 256) begin n_bad++;
            $display("FAIL timeout_cycles: got req=%0d stall=%0d hung=%0b want 255/256/0",
                rn, sn, hg); end
        n_cmp++; if (bus_err_o !== 1'b1 || wb_data_o !== 32'd0) begin n_bad++;
            $display("FAIL timeout_result: got err=%b data=%h want 1/0",
                bus_err_o, wb_data_o); end
        run_access(1'b0, 4'b0011, 32'h604, 32'd0, 32'h0000_8001, 1'b1,
                   1'b1, 1'b1, 5'd13, 32'h94, 1'b0, 2,
                   sn, rn, bok, hg, oa, owe, ob, ow);
        n_cmp++; if (hg || bus_err_o !== 1'b1 || wb_data_o !== 32'hFFFF_8001) begin
            n_bad++; $display("FAIL timeout_sticky: got err=%b data=%h want 1/ffff8001",
                bus_err_o, wb_data_o); end
    endtask

    task automatic test_reset_mid_busy();
        // Store in flight; wb would retire regwr=1 if not killed.
        drive_nop();
        mem_dmen_i        = 1'b1;
        mem_memwr_i       = 1'b1;
        mem_regwr_i       = 1'b1;
        mem_bytesel_i     = 4'b1111;
        mem_result_i      = 32'h700;
        mem_rt_i          = 32'hCAFE_F00D;
        mem_regdst_addr_i = 5'd14;
        mem_pc_i          = 32'hA0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        n_cmp++; if (dbus_req_o !== 1'b1) begin n_bad++;
            $display("FAIL mid_busy_req: got %b want 1", dbus_req_o); end
        reset = 1'b0;
        #1;
        n_cmp++; if (dbus_req_o !== 1'b0 || dbus_we_o !== 1'b0 ||
                     dbus_addr_o !== 32'd0 || bus_err_o !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_bus: got req=%b we=%b addr=%h err=%b want 0",
                dbus_req_o, dbus_we_o, dbus_addr_o, bus_err_o); end
        n_cmp++; if ({wb_regwr_o, wb_regdst_addr_o, wb_data_o, wb_pc_o} !== '0) begin
            n_bad++; $display("FAIL async_reset_wb: got %b/%h/%h/%h want 0",
                wb_regwr_o, wb_regdst_addr_o, wb_data_o, wb_pc_o); end
        // Release between edges with dmen held: no request until next edge.
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (dbus_req_o !== 1'b0) begin n_bad++;
            $display("FAIL release_req: got %b want 0", dbus_req_o); end
        @(posedge clk);
        #1;
        n_cmp++; if (dbus_req_o !== 1'b1 || dbus_wdata_o !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL restart_req: got %b/%h want 1/cafef00d",
                dbus_req_o, dbus_wdata_o); end
        dbus_ack_i = 1'b1;
        @(posedge clk);
        #1;
        dbus_ack_i = 1'b0;
        @(posedge clk);
        #2;
        drive_nop();
        n_cmp++; if (wb_regwr_o !== 1'b1 || wb_data_o !== 32'h700 ||
                     wb_regdst_addr_o !== 5'd14) begin
            n_bad++; $display("FAIL restart_wb: got %b/%h/%h want 1/700/0e",
                wb_regwr_o, wb_data_o, wb_regdst_addr_o); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_word_load();
        test_signed_byte();
        test_half_store();
        test_random();
        test_wash();
        test_timeout();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces all state to its reset values.
REQ-004 mem_regwr_i, mem_memtoreg_i, mem_memwr_i, mem_dmen_i  input  1 each  control from the EX/MEM register.
REQ-005 mem_bytesel_i  input  4  lane enables (0001/0010/0100/1000 byte, 0011/1100 half, 1111 word); mem_extsigned_i  input  1  sign-extend loads.
REQ-006 mem_result_i  input  32  ALU result / effective address; mem_rt_i  input  32  store data; mem_regdst_addr_i  input  5; mem_pc_i  input  32.
REQ-007 wash_memwb_i  input  1  synchronous flush of the MEM/WB outputs.
REQ-008 dbus_req_o, dbus_we_o  output  1 each; dbus_addr_o  output  32; dbus_wdata_o  output  32; dbus_be_o  output  4.
REQ-009 dbus_ack_i  input  1  transfer complete; dbus_rdata_i  input  32  read word.
REQ-010 mem_stall_o  output  1  freeze of IF..EX/MEM (drives the EX/MEM hold input).
REQ-011 wb_regwr_o  output  1; wb_regdst_addr_o  output  5; wb_data_o  output  32; wb_pc_o  output  32  registered MEM/WB outputs.
REQ-012 bus_err_o  output  1  sticky timeout flag.

Function
REQ-013 Bus FSM states SHALL be IDLE, BUSY, DONE.
REQ-014 IDLE with mem_dmen_i=1 -> BUSY next edge; otherwise stay IDLE.
REQ-015 In BUSY dbus_req_o SHALL be 1; dbus_ack_i=1 -> capture dbus_rdata_i, go DONE (same-cycle ack allowed, minimum access 2 cycles).
REQ-016 DONE -> IDLE unconditionally after one cycle.
REQ-017 mem_stall_o SHALL equal mem_dmen_i AND state!=DONE (combinational).
REQ-018 dbus_addr_o = {mem_result_i[31:2],2'b00}; dbus_we_o = mem_memwr_i; dbus_be_o = mem_bytesel_i; all driven only while in BUSY, else zero.
REQ-019 dbus_wdata_o SHALL replicate store data: byte -> rt[7:0] on all four lanes; half -> rt[15:0] on both halves; word -> rt.
REQ-020 Load data SHALL be right-justified from the selected lanes, then zero- or sign-extended (mem_extsigned_i) to 32 bits; word loads pass unchanged.
REQ-021 MEM/WB outputs SHALL update every edge: if wash_memwb_i or mem_stall_o -> bubble (all zero); else regwr/addr/pc from inputs, data = memtoreg ? aligned load : mem_result_i.
REQ-022 BUSY counter SHALL count cycles without ack; on count reaching 255, set bus_err_o, go DONE with load data 0.
REQ-023 bus_err_o SHALL stay set until reset.
REQ-024 wash_memwb_i SHALL NOT abort a bus access in progress.
REQ-025 Non-memory instructions (mem_dmen_i=0) SHALL pass through with 1-cycle latency and no stall.

Reset
REQ-026 Reset low SHALL immediately force state=IDLE, dbus_req_o=0, counter=0, bus_err_o=0, all wb_* outputs=0, even mid-access.
REQ-027 After reset release, first access SHALL start no earlier than the next edge.

Structure
REQ-028 FSM state encoding, bytesel constants and TIMEOUT=255 SHALL live in a shared package mem_pkg.
REQ-029 Load alignment/extension SHALL be one combinational sub-module, load_align.

Verification
REQ-030 ALU op, dmen=0, result=0x1234_5678, regdst=5 -> next edge wb_data=0x1234_5678, wb_regdst=5, stall never high.
REQ-031 Word load addr 0x100, ack 3 cycles after req, rdata=0xDEAD_BEEF -> stall high 4 cycles, req high 3 cycles, wb_data=0xDEAD_BEEF once, bubble during stall.
REQ-032 Signed byte load bytesel=0100, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-033 Half store rt=0x0000_ABCD, bytesel=1100 -> dbus_wdata=0xABCD_ABCD, be=1100, we=1, wb_regwr=0.
REQ-034 Load with no ack -> after 255 BUSY cycles bus_err_o=1, wb_data=0, stall releases.
REQ-035 Reset low mid-BUSY -> req, stall source state, wb_* and bus_err_o zero asynchronously; no write retire.
